// File: rtl/module_acc_ctrl_pkg.sv
// module_acc_ctrl_pkg: shared sequencer state encoding and default write-back latency
package module_acc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } acc_state_t;

  // RAM read register plus adder register
  localparam int WB_DELAY_DEF = 2;

endpackage

// File: rtl/module_acc_ctrl_delay.sv
// module_delay_line: width x depth shift register with asynchronous clear
module module_delay_line #(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] pipe [D];

  // shift one stage per cycle; reset flushes every stage so in-flight entries vanish
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[D-1];

endmodule

// File: rtl/module_acc_ctrl.sv
// module_acc_ctrl: accumulator-bank sequencer; optional stall counter under ACC_CTRL_STALL_CNT_EN
module module_acc_ctrl
  import module_acc_ctrl_pkg::*;
#(
  parameter int DEPTH    = 114*114,
  parameter int ADDR_BIT = 14,
  parameter int CH_BIT   = 8,
  parameter int WB_DELAY = WB_DELAY_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CH_BIT-1:0]   num_ch,
  input  logic                in_valid,
  input  logic                in_zero,
  output logic                in_ready,
  output logic                read_en,
  output logic                write_en,
  output logic [ADDR_BIT-1:0] read_addr,
  output logic [ADDR_BIT-1:0] write_addr,
  output logic                prev_data_zero,
  output logic                curr_data_zero,
  output logic                res_valid,
  output logic [ADDR_BIT-1:0] res_addr,
  output logic                busy,
  output logic                done
`ifdef ACC_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  localparam int DW = $clog2(WB_DELAY + 1);

  acc_state_t          state;
  logic [ADDR_BIT-1:0] pix_cnt;
  logic [CH_BIT-1:0]   ch_cnt, ch_last;
  logic [DW-1:0]       drain_cnt;
  logic                acc, last_pass, pix_end, wb_last;

  assign acc       = in_valid & (state == RUN);
  assign last_pass = ch_cnt == ch_last;
  assign pix_end   = pix_cnt == ADDR_BIT'(DEPTH - 1);
  assign in_ready  = state == RUN;
  assign busy      = state != IDLE;
  assign done      = state == DONE;

  // read-side controls are combinational on the accepting cycle and quiet otherwise
  always_comb begin
    read_en        = acc;
    read_addr      = acc ? pix_cnt : '0;
    prev_data_zero = acc & (ch_cnt == '0);
    curr_data_zero = acc & in_zero;
  end

  // layer sequencer: walks pixels then channels, then waits for the write pipe to empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pix_cnt   <= '0;
      ch_cnt    <= '0;
      ch_last   <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state   <= RUN;
          pix_cnt <= '0;
          ch_cnt  <= '0;
          ch_last <= (num_ch == '0) ? '0 : num_ch - CH_BIT'(1);
        end
        RUN: if (acc) begin
          pix_cnt <= pix_end ? '0 : pix_cnt + ADDR_BIT'(1);
          if (pix_end) begin
            ch_cnt    <= last_pass ? '0 : ch_cnt + CH_BIT'(1);
            drain_cnt <= '0;
            if (last_pass) state <= DRAIN;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + DW'(1);
          if (drain_cnt == DW'(WB_DELAY - 1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  module_delay_line #(
    .W (ADDR_BIT + 2),
    .D (WB_DELAY)
  ) u_wb_pipe (
    .clk (clk),
    .rst (rst),
    .d   ({read_en, read_addr, acc & last_pass}),
    .q   ({write_en, write_addr, wb_last})
  );

  assign res_valid = write_en & wb_last;
  assign res_addr  = write_addr;

`ifdef ACC_CTRL_STALL_CNT_EN
  // counts RUN cycles without a presented beat, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (state == IDLE && start) stall_cnt <= '0;
    else if (state == RUN && !in_valid && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_module_acc_ctrl.sv
// tb_module_acc_ctrl: table-driven read-side vectors with a write-back scoreboard
module tb_module_acc_ctrl;

  localparam int DEPTH = 4;
  localparam int AW    = 14;
  localparam int CW    = 8;
  localparam int WBD   = 2;

  logic          clk = 0, rst = 1, start = 0, in_valid = 0, in_zero = 0;
  logic [CW-1:0] num_ch = '0;
  logic          in_ready, read_en, write_en, prev_data_zero, curr_data_zero;
  logic          res_valid, busy, done;
  logic [AW-1:0] read_addr, write_addr, res_addr;
`ifdef ACC_CTRL_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  module_acc_ctrl #(.DEPTH(DEPTH), .ADDR_BIT(AW), .CH_BIT(CW), .WB_DELAY(WBD)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .num_ch         (num_ch),
    .in_valid       (in_valid),
    .in_zero        (in_zero),
    .in_ready       (in_ready),
    .read_en        (read_en),
    .write_en       (write_en),
    .read_addr      (read_addr),
    .write_addr     (write_addr),
    .prev_data_zero (prev_data_zero),
    .curr_data_zero (curr_data_zero),
    .res_valid      (res_valid),
    .res_addr       (res_addr),
    .busy           (busy),
    .done           (done)
`ifdef ACC_CTRL_STALL_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          st, v, z, rdy, ren;
    logic [AW-1:0] addr;
    logic          pdz, cdz, res, lst;
  } vec_t;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic          res;
  } wb_t;

  vec_t tbl[$];
  wb_t  sb[$];
  int   checks = 0, failures = 0, cyc = 0, done_due = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // write-back scoreboard and done timing, sampled mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      chk("write_en", write_en, 1);
      chk("write_addr", write_addr, sb[0].addr);
      chk("res_valid", res_valid, sb[0].res);
      chk("res_addr", res_addr, sb[0].addr);
      void'(sb.pop_front());
    end else begin
      chk("write_en_idle", write_en, 0);
      chk("res_valid_idle", res_valid, 0);
    end
    chk("done", done, cyc == done_due);
  end

  function automatic void add(logic st, v, z, rdy, ren, int addr, logic pdz, cdz, res, lst);
    vec_t r;
    r = '{st, v, z, rdy, ren, AW'(addr), pdz, cdz, res, lst};
    tbl.push_back(r);
  endfunction

  task automatic row(input vec_t r);
    @(posedge clk); #1;
    start = r.st; in_valid = r.v; in_zero = r.z;
    #3;
    chk("in_ready", in_ready, r.rdy);
    chk("read_en", read_en, r.ren);
    chk("prev_data_zero", prev_data_zero, r.pdz);
    chk("curr_data_zero", curr_data_zero, r.cdz);
    if (r.ren) begin
      chk("read_addr", read_addr, r.addr);
      sb.push_back('{cyc + WBD, r.addr, r.res});
    end
    if (r.lst) done_due = cyc + WBD + 1;
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) row(tbl[i]);
    tbl.delete();
  endtask

  task automatic add_tail();
    for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic begin_layer(input int n);
    @(posedge clk); #1;
    start = 1; num_ch = CW'(n); in_valid = 0; in_zero = 0;
    #3;
    chk("ready_at_start", in_ready, 0);
    chk("busy_before_start", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #4;
    chk("rst_read_en", read_en, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_read_addr", read_addr, 0);
    chk("rst_write_addr", write_addr, 0);
    @(posedge clk); #1 rst = 0;

    // two channels, continuous beats
    begin_layer(2);
    for (int i = 0; i < 8; i++) add(0, 1, 0, 1, 1, i % 4, i < 4, 0, i >= 4, i == 7);
    add_tail();
    run_tbl();
    chk("busy_after_layer", busy, 0);

    // zero channels behaves as one
    begin_layer(0);
    for (int i = 0; i < 4; i++) add(0, 1, 0, 1, 1, i, 1, 0, 1, i == 3);
    add_tail();
    run_tbl();

    // gapped beats keep counters and bubbles
    begin_layer(1);
    for (int i = 0; i < 7; i++) add(0, i % 2 == 0, 0, 1, i % 2 == 0, i / 2, i % 2 == 0, 0, i % 2 == 0, i == 6);
    add_tail();
    run_tbl();
`ifdef ACC_CTRL_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, 3);
`endif

    // padding beat on second pass and start pulses while running
    begin_layer(2);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 1, 1, i, 1, 0, 0, 0);
    run_tbl();
    num_ch = CW'(5);
    for (int i = 3; i < 8; i++) add(i == 3 || i == 4, 1, i == 6, 1, 1, i % 4, i < 4, i == 6, i >= 4, i == 7);
    add_tail();
    run_tbl();

    // reset one cycle after a read drops in-flight writes
    begin_layer(2);
    for (int i = 0; i < 2; i++) add(0, 1, 0, 1, 1, i, 1, 0, 0, 0);
    run_tbl();
    @(posedge clk); #1;
    rst = 1; in_valid = 0; sb.delete();
    #3;
    chk("mid_rst_read_en", read_en, 0);
    chk("mid_rst_write_en", write_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    @(posedge clk); #1 rst = 0;
    add_tail();
    run_tbl();
    begin_layer(1);
    for (int i = 0; i < 4; i++) add(0, 1, 0, 1, 1, i, 1, 0, 1, i == 3);
    add_tail();
    run_tbl();

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
